// File: rtl/m_bridge_timer.sv
// m_bridge_timer: M-stage system bridge with two memory-mapped timers.
//   Decodes the formatted byte address into the data-memory window or one of
//   two timer register blocks (CTRL +0, PRESET +4, COUNT +8), returns the read
//   word, flags illegal accesses and raises per-timer interrupt requests.
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   data_addr/wd      byte address and lane-aligned write data from formatter
//   data_byte_we      byte write enables (4'b0000 = no write)
//   load, store       access type of the M-stage instruction
//   data_rd           read word back to formatter (combinational)
//   m_data_*          external data-memory port (address/wdata/byteen/rdata)
//   bus_err           illegal access (combinational, inputs only)
//   irq_tc0, irq_tc1  timer interrupt requests (registered)
module m_bridge_timer #(
  parameter logic [31:0] DM_TOP   = 32'h0000_2fff,
  parameter logic [31:0] TC0_BASE = 32'h0000_7f00,
  parameter logic [31:0] TC1_BASE = 32'h0000_7f10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wd,
  input  logic [3:0]  data_byte_we,
  input  logic        load,
  input  logic        store,
  output logic [31:0] data_rd,
  output logic [31:0] m_data_addr,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  input  logic [31:0] m_data_rdata,
  output logic        bus_err,
  output logic        irq_tc0,
  output logic        irq_tc1
);

  localparam int unsigned NUM_TC = 2;
  localparam int unsigned CTRL_W = 4;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

  // Address decode results
  logic              in_dm;
  logic [NUM_TC-1:0] in_tc;
  logic              tc_idx;
  logic [3:0]        sel_off;
  logic [NUM_TC-1:0] wr_ctrl;
  logic [NUM_TC-1:0] wr_preset;

  // Timer state
  logic [CTRL_W-1:0] ctrl_q    [NUM_TC];
  logic [CTRL_W-1:0] ctrl_d    [NUM_TC];
  logic [WORD_W-1:0] preset_q  [NUM_TC];
  logic [WORD_W-1:0] preset_d  [NUM_TC];
  logic [WORD_W-1:0] count_q   [NUM_TC];
  logic [WORD_W-1:0] count_d   [NUM_TC];
  tc_state_e         state_q   [NUM_TC];
  tc_state_e         state_d   [NUM_TC];
  logic [NUM_TC-1:0] flag_q;
  logic [NUM_TC-1:0] flag_d;
  logic [NUM_TC-1:0] irq_q;
  logic [NUM_TC-1:0] irq_d;

  // Address decode, access checking and write strobes
  always_comb begin
    in_dm    = (data_addr <= DM_TOP);
    in_tc[0] = (data_addr >= TC0_BASE) && (data_addr <= TC0_BASE + 32'd11);
    in_tc[1] = (data_addr >= TC1_BASE) && (data_addr <= TC1_BASE + 32'd11);
    tc_idx   = in_tc[1];
    sel_off  = 4'(data_addr - (in_tc[1] ? TC1_BASE : TC0_BASE));

    // Sub-word timer loads arrive with non-zero low address bits, so the
    // alignment term covers them as well as misaligned word accesses.
    bus_err = (load || store) &&
              ((!in_dm && (in_tc == '0)) ||
               ((in_tc != '0) &&
                ((store && (data_byte_we != 4'hf)) ||
                 (data_addr[1:0] != 2'b00) ||
                 (store && (sel_off[3:2] == 2'd2)))));

    for (int i = 0; i < NUM_TC; i++) begin
      wr_ctrl[i]   = in_tc[i] && (data_byte_we == 4'hf) && !bus_err && (sel_off == 4'h0);
      wr_preset[i] = in_tc[i] && (data_byte_we == 4'hf) && !bus_err && (sel_off == 4'h4);
    end
  end

  // External data-memory port
  always_comb begin
    m_data_addr   = data_addr;
    m_data_wdata  = data_wd;
    m_data_byteen = (in_dm && !bus_err) ? data_byte_we : 4'b0000;
  end

  // Read mux; timer reads show pre-edge register values
  always_comb begin
    data_rd = '0;
    if (in_dm) begin
      data_rd = m_data_rdata;
    end else if (in_tc != '0) begin
      case (sel_off[3:2])
        2'd0:    data_rd = {28'd0, ctrl_q[tc_idx]};
        2'd1:    data_rd = preset_q[tc_idx];
        2'd2:    data_rd = count_q[tc_idx];
        default: data_rd = '0;
      endcase
    end
  end

  // Timer next-state logic
  always_comb begin
    for (int i = 0; i < NUM_TC; i++) begin
      ctrl_d[i]   = ctrl_q[i];
      preset_d[i] = preset_q[i];
      count_d[i]  = count_q[i];
      state_d[i]  = state_q[i];
      flag_d[i]   = flag_q[i];

      // Flag sets on leaving INT; auto-reload mode drops it one cycle later.
      if (state_q[i] == ST_INT) begin
        flag_d[i] = 1'b1;
      end else if (ctrl_q[i][2:1] == 2'b01) begin
        flag_d[i] = 1'b0;
      end

      case (state_q[i])
        ST_IDLE: begin
          if (ctrl_q[i][0]) state_d[i] = ST_LOAD;
        end
        ST_LOAD: begin
          count_d[i] = preset_q[i];
          state_d[i] = ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl_q[i][0]) begin
            state_d[i] = ST_IDLE;
          end else if (count_q[i] <= 32'd1) begin
            count_d[i] = '0;
            state_d[i] = ST_INT;
          end else begin
            count_d[i] = count_q[i] - 32'd1;
          end
        end
        ST_INT: begin
          // Auto-reload goes straight to LOAD so the period is PRESET+2.
          if (ctrl_q[i][2:1] == 2'b01) begin
            state_d[i] = ST_LOAD;
          end else begin
            ctrl_d[i][0] = 1'b0;
            state_d[i]   = ST_IDLE;
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase

      if (wr_preset[i]) preset_d[i] = data_wd;

      // A CTRL write overrides whatever the FSM was about to do.
      if (wr_ctrl[i]) begin
        ctrl_d[i]  = data_wd[CTRL_W-1:0];
        count_d[i] = count_q[i];
        flag_d[i]  = 1'b0;
        state_d[i] = ST_IDLE;
      end

      irq_d[i] = flag_d[i] && ctrl_d[i][3];
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q   <= '{default: '0};
      preset_q <= '{default: '0};
      count_q  <= '{default: '0};
      state_q  <= '{default: ST_IDLE};
      flag_q   <= '0;
      irq_q    <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      state_q  <= state_d;
      flag_q   <= flag_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_tc0 = irq_q[0];
  assign irq_tc1 = irq_q[1];

endmodule

// File: tb/tb_m_bridge_timer.sv
// Self-checking bench for m_bridge_timer: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_m_bridge_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_addr, data_wd, m_data_rdata;
  logic [3:0]  data_byte_we;
  logic        load, store;
  logic [31:0] data_rd, m_data_addr, m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic        bus_err, irq_tc0, irq_tc1;

  always #5 clk = ~clk;

  m_bridge_timer dut (
    .clk(clk), .reset(reset), .data_addr(data_addr), .data_wd(data_wd),
    .data_byte_we(data_byte_we), .load(load), .store(store), .data_rd(data_rd),
    .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
    .m_data_byteen(m_data_byteen), .m_data_rdata(m_data_rdata),
    .bus_err(bus_err), .irq_tc0(irq_tc0), .irq_tc1(irq_tc1)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: per timer, registers plus "age" = edges since the
  // timer left idle (1 = load cycle, then count cycles, then interrupt).
  logic [3:0]  mc    [2];
  logic [31:0] mp    [2];
  logic [31:0] mcnt  [2];
  logic [31:0] mload [2];
  bit          mact  [2];
  bit          mflag [2];
  longint      mage  [2];

  logic [31:0] last_rd;
  logic [3:0]  last_be;
  logic        last_err, last_irq0, last_irq1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] base_of(input int i);
    return (i == 0) ? 32'h7f00 : 32'h7f10;
  endfunction

  // -1 when not a timer address, else timer index
  function automatic int tc_of(input logic [31:0] a);
    for (int i = 0; i < 2; i++)
      if (a >= base_of(i) && a <= base_of(i) + 11) return i;
    return -1;
  endfunction

  function automatic logic exp_err(input logic [31:0] a, input logic [3:0] be, input logic ld, input logic st);
    int t = tc_of(a);
    logic [31:0] off;
    if (!(ld || st)) return 1'b0;
    if (a > 32'h2fff && t < 0) return 1'b1;
    if (t < 0) return 1'b0;
    off = a - base_of(t);
    return (st && be != 4'hf) || (a % 4 != 0) || (st && off / 4 == 2);
  endfunction

  // Edge at which the interrupt state is occupied, counted from idle-exit
  function automatic longint int_age(input logic [31:0] p);
    return (p <= 32'd1) ? 64'sd3 : longint'(p) + 2;
  endfunction

  task automatic model_edge(input bit rst, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] be, input logic ld, input logic st);
    int t;
    logic err, mode01, was_int, wc, wp;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mc[i] = 0; mp[i] = 0; mcnt[i] = 0; mload[i] = 0;
        mact[i] = 0; mflag[i] = 0; mage[i] = 0;
      end
      return;
    end
    t   = tc_of(a);
    err = exp_err(a, be, ld, st);
    for (int i = 0; i < 2; i++) begin
      wc      = (t == i) && be == 4'hf && !err && a == base_of(i);
      wp      = (t == i) && be == 4'hf && !err && a == base_of(i) + 4;
      mode01  = (mc[i][2:1] == 2'b01);
      was_int = mact[i] && mage[i] >= 2 && mage[i] == int_age(mload[i]);
      if (wc) begin
        mc[i] = wd[3:0]; mflag[i] = 0; mact[i] = 0;
      end else begin
        if (was_int) mflag[i] = 1;
        else if (mode01) mflag[i] = 0;
        if (!mact[i]) begin
          if (mc[i][0]) begin mact[i] = 1; mage[i] = 1; end
        end else if (was_int) begin
          if (mode01) mage[i] = 1;
          else begin mact[i] = 0; mc[i][0] = 1'b0; end
        end else if (mage[i] == 1) begin
          mload[i] = mp[i]; mcnt[i] = mp[i]; mage[i] = 2;
        end else begin
          mage[i]++;
          mcnt[i] = (mage[i] >= int_age(mload[i])) ? 32'd0
                  : 32'(longint'(mload[i]) - (mage[i] - 2));
        end
      end
      if (wp) mp[i] = wd;
    end
  endtask

  // One bus cycle: drive, compare every output against the model, then step it.
  task automatic cyc(input bit rst, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input logic ld, input logic st);
    int t;
    logic e;
    logic [31:0] rd_exp;
    @(negedge clk);
    reset = rst ? 1'b0 : 1'b1;
    data_addr = a; data_wd = wd; data_byte_we = be; load = ld; store = st;
    m_data_rdata = $urandom;
    #1;
    t = tc_of(a);
    e = exp_err(a, be, ld, st);
    rd_exp = 32'h0;
    if (a <= 32'h2fff) rd_exp = m_data_rdata;
    else if (t >= 0) begin
      case ((a - base_of(t)) / 4)
        0:       rd_exp = {28'd0, mc[t]};
        1:       rd_exp = mp[t];
        default: rd_exp = mcnt[t];
      endcase
    end
    chk("bus_err", 32'(bus_err), 32'(e));
    chk("byteen", 32'(m_data_byteen), (a <= 32'h2fff && !e) ? 32'(be) : 32'h0);
    chk("data_rd", data_rd, rd_exp);
    chk("m_addr", m_data_addr, a);
    chk("m_wdata", m_data_wdata, wd);
    chk("irq_tc0", 32'(irq_tc0), 32'(mflag[0] && mc[0][3]));
    chk("irq_tc1", 32'(irq_tc1), 32'(mflag[1] && mc[1][3]));
    last_rd = data_rd; last_err = bus_err; last_be = m_data_byteen;
    last_irq0 = irq_tc0; last_irq1 = irq_tc1;
    @(posedge clk);
    model_edge(rst, a, wd, be, ld, st);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 32'h0000_1000, 32'h0, 4'h0, 0, 0);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(0, a, d, 4'hf, 0, 1);
  endtask
  task automatic rd(input logic [31:0] a);
    cyc(0, a, 32'h0, 4'h0, 1, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 9);
    int t = $urandom_range(0, 1);
    if (r <= 2) return 32'($urandom_range(0, 32'hbff)) * 4;
    if (r == 3) return 32'h2ff8 + 32'($urandom_range(0, 15));
    if (r <= 7) begin
      if ($urandom_range(0, 4) != 0) return base_of(t) + 32'($urandom_range(0, 2)) * 4;
      return base_of(t) + 32'($urandom_range(0, 11));
    end
    if (r == 8) return 32'h7f0c + 32'($urandom_range(0, 7));
    return $urandom;
  endfunction

  initial begin
    int pulses[$];
    int exp_cnt[8] = '{0, 0, 5, 4, 3, 2, 1, 0};
    reset = 1'b0; data_addr = 0; data_wd = 0; data_byte_we = 0;
    load = 0; store = 0; m_data_rdata = 0;
    for (int i = 0; i < 2; i++) model_edge(1, 0, 0, 0, 0, 0);

    cyc(1, 32'h0, 32'h0, 4'h0, 0, 0);
    cyc(1, 32'h0, 32'h0, 4'h0, 0, 0);
    rd(32'h7f00);
    chk("reset_ctrl", last_rd, 32'h0);
    chk("reset_irq", 32'({last_irq0, last_irq1}), 32'h0);

    // DM boundary
    cyc(0, 32'h2ffc, 32'h1234_5678, 4'hf, 0, 1);
    chk("dm_top_be", 32'(last_be), 32'hf);
    chk("dm_top_err", 32'(last_err), 32'h0);
    cyc(0, 32'h3000, 32'h1234_5678, 4'hf, 0, 1);
    chk("dm_out_be", 32'(last_be), 32'h0);
    chk("dm_out_err", 32'(last_err), 32'h1);

    // TC0 one-shot countdown
    wr(32'h7f04, 32'd5);
    wr(32'h7f00, 32'h9);
    for (int k = 0; k < 8; k++) begin
      rd(32'h7f08);
      chk($sformatf("tc0_count%0d", k), last_rd, 32'(exp_cnt[k]));
    end
    rd(32'h7f00);
    chk("tc0_en_clr", last_rd, 32'h8);
    chk("tc0_irq_up", 32'(last_irq0), 32'h1);
    idle(3);
    chk("tc0_irq_hold", 32'(last_irq0), 32'h1);
    wr(32'h7f00, 32'h0);
    idle(1);
    chk("tc0_irq_clr", 32'(last_irq0), 32'h0);

    // TC1 auto-reload pulses
    wr(32'h7f14, 32'd3);
    wr(32'h7f10, 32'hb);
    for (int k = 0; k < 30; k++) begin
      idle(1);
      if (last_irq1) pulses.push_back(k);
    end
    chk("tc1_npulse", 32'(pulses.size() >= 4), 32'h1);
    for (int k = 1; k < pulses.size(); k++)
      chk("tc1_period", 32'(pulses[k] - pulses[k-1]), 32'd5);
    wr(32'h7f10, 32'h3);
    pulses.delete();
    for (int k = 0; k < 20; k++) begin
      idle(1);
      if (last_irq1) pulses.push_back(k);
    end
    chk("tc1_masked", 32'(pulses.size()), 32'h0);

    // Illegal timer accesses leave registers alone
    cyc(0, 32'h7f04, 32'h0000_aaaa, 4'b0011, 0, 1);
    chk("sh_err", 32'(last_err), 32'h1);
    cyc(0, 32'h7f08, 32'h0000_0077, 4'hf, 0, 1);
    chk("sw_count_err", 32'(last_err), 32'h1);
    rd(32'h7f02);
    chk("lw_mis_err", 32'(last_err), 32'h1);
    rd(32'h7f04);
    chk("preset_kept", last_rd, 32'd5);
    rd(32'h7f08);
    chk("count_kept", last_rd, 32'd0);

    // Disable mid-count holds COUNT
    wr(32'h7f04, 32'd6);
    wr(32'h7f00, 32'h1);
    idle(6);
    wr(32'h7f00, 32'h0);
    rd(32'h7f08);
    chk("stop_count", last_rd, 32'd2);
    idle(5);
    rd(32'h7f08);
    chk("stop_hold", last_rd, 32'd2);
    chk("stop_noirq", 32'(last_irq0), 32'h0);

    // Reset mid-count
    wr(32'h7f04, 32'd5);
    wr(32'h7f00, 32'h9);
    idle(4);
    cyc(1, 32'h7f08, 32'h0, 4'h0, 1, 0);
    chk("pre_rst_count", last_rd, 32'd3);
    rd(32'h7f00);
    chk("rst_ctrl", last_rd, 32'h0);
    rd(32'h7f08);
    chk("rst_count", last_rd, 32'h0);
    rd(32'h7f04);
    chk("rst_preset", last_rd, 32'h0);
    chk("rst_irqs", 32'({last_irq0, last_irq1}), 32'h0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      logic [31:0] a, wd;
      logic [3:0]  be;
      logic        ld, st;
      int          op;
      a  = rand_addr();
      op = $urandom_range(0, 9);
      ld = (op >= 7);
      st = (op >= 4 && op <= 6);
      be = st ? (($urandom_range(0, 4) != 0) ? 4'hf : 4'($urandom)) : 4'h0;
      wd = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 15));
      cyc($urandom_range(0, 299) == 0, a, wd, be, ld, st);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
